// File: rtl/menu_pkg.sv
// Shared constants and types for the menu text screen.
package menu_pkg;

  localparam int unsigned CELL_W        = 8;
  localparam int unsigned CODE_W        = 8;
  localparam int unsigned MENU_TEXT_LEN = 182;

  localparam logic [CODE_W-1:0] CHAR_SPACE  = 8'h20;
  localparam logic [CODE_W-1:0] CHAR_CURSOR = 8'h5F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TYPING = 2'd1,
    DONE   = 2'd2
  } reveal_state_t;

  // Counter width for a 0..div-1 count, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/char_reveal_ctrl_if.sv
// Bus between the address generator / ROM / font stage and the reveal controller.
interface char_reveal_ctrl_if;
  import menu_pkg::*;

  logic              start;
  logic              skip;
  logic [CELL_W-1:0] char_xy_in;
  logic [CELL_W-1:0] char_xy_out;
  logic [CODE_W-1:0] rom_code;
  logic [CODE_W-1:0] char_code_out;
  logic              busy;
  logic              done;

  modport master (
    output start, skip, char_xy_in, rom_code,
    input  char_xy_out, char_code_out, busy, done
  );

  modport slave (
    input  start, skip, char_xy_in, rom_code,
    output char_xy_out, char_code_out, busy, done
  );

endinterface

// File: rtl/tick_divider.sv
// Free-running 0..DIV-1 divider that runs only while enabled and pulses tick on the last count.
module tick_divider
  import menu_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W    = cnt_width(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/char_reveal_ctrl.sv
// Typewriter reveal: passes cell addresses to the ROM and masks its codes so text appears
// one cell per tick behind a blinking underscore cursor.
module char_reveal_ctrl
  import menu_pkg::*;
#(
  parameter int unsigned TEXT_LEN  = MENU_TEXT_LEN,
  parameter int unsigned TICK_DIV  = 2_600_000,
  parameter int unsigned BLINK_DIV = 32_500_000
) (
  input  logic                clk,
  input  logic                rst_n,
  char_reveal_ctrl_if.slave   bus
);

  localparam logic [CELL_W-1:0] LEN_C  = CELL_W'(TEXT_LEN);
  localparam logic [CELL_W-1:0] LAST_C = CELL_W'(TEXT_LEN - 1);

  reveal_state_t     state_q, state_d;
  logic [CELL_W-1:0] reveal_q, reveal_d;
  logic              cursor_q, cursor_d;
  logic [CELL_W-1:0] xy_q;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              char_tick;
  logic              blink_tick;
  logic              typing;
  logic [CODE_W-1:0] code_c;

  assign typing          = (state_q == TYPING);
  assign bus.char_xy_out = bus.char_xy_in;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.char_code_out = code_c;

  tick_divider #(.DIV(TICK_DIV)) u_char_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (typing),
    .clr   (bus.start),
    .tick  (char_tick)
  );

  tick_divider #(.DIV(BLINK_DIV)) u_blink_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (typing),
    .clr   (bus.start),
    .tick  (blink_tick)
  );

  // Next state; start overrides skip and any pending tick.
  always_comb begin
    state_d  = state_q;
    reveal_d = reveal_q;
    cursor_d = cursor_q;
    if (bus.start) begin
      state_d  = TYPING;
      reveal_d = '0;
      cursor_d = 1'b1;
    end else if (typing) begin
      if (blink_tick) begin
        cursor_d = ~cursor_q;
      end
      if (bus.skip || (char_tick && (reveal_q == LAST_C))) begin
        state_d  = DONE;
        reveal_d = LEN_C;
      end else if (char_tick) begin
        reveal_d = reveal_q + CELL_W'(1);
      end
    end
    busy_d = (state_d == TYPING);
    done_d = (state_d == DONE) && typing;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      reveal_q <= '0;
      cursor_q <= 1'b1;
      xy_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      reveal_q <= reveal_d;
      cursor_q <= cursor_d;
      xy_q     <= bus.char_xy_in;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // xy_q lines up with the ROM's registered code; cells past the text never pass the compare.
  always_comb begin
    code_c = CHAR_SPACE;
    if (xy_q < reveal_q) begin
      code_c = bus.rom_code;
    end else if (typing && (xy_q == reveal_q) && cursor_q) begin
      code_c = CHAR_CURSOR;
    end
  end

endmodule

// File: tb/tb_char_reveal_ctrl.sv
// Randomised scoreboard bench for char_reveal_ctrl against a time-based reveal model.
module tb_char_reveal_ctrl;
  import menu_pkg::*;

  localparam int TL = 182;
  localparam int TD = 4;
  localparam int BD = 6;

  typedef struct {
    int         addr;
    logic [7:0] code;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic chk_req;
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  bit started;
  int start_edge;
  int skip_edge;

  always #5 clk = ~clk;

  char_reveal_ctrl_if bus();

  char_reveal_ctrl #(.TEXT_LEN(TL), .TICK_DIV(TD), .BLINK_DIV(BD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [7:0] rom_fn(input int a);
    if (a >= TL) return 8'h20;
    case (a)
      0:       return 8'h4C;
      1:       return 8'h69;
      2:       return 8'h74;
      default: return 8'(32'h41 + (a % 26));
    endcase
  endfunction

  // Behavioural ROM with one cycle of latency.
  always @(posedge clk) bus.rom_code <= rom_fn(int'(bus.char_xy_out));
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Model quantities as seen just after clock edge e.
  function automatic int m_reveal(input int e);
    int r;
    if (!started) return 0;
    if (skip_edge >= 0 && e >= skip_edge) return TL;
    r = (e - start_edge) / TD;
    return (r > TL) ? TL : r;
  endfunction

  function automatic bit m_typing(input int e);
    return started && (m_reveal(e) < TL);
  endfunction

  function automatic bit m_cursor(input int e);
    return (((e - start_edge) / BD) % 2) == 0;
  endfunction

  function automatic bit m_done(input int e);
    int de;
    if (!started) return 1'b0;
    de = (skip_edge >= 0) ? skip_edge : start_edge + TL * TD;
    return e == de;
  endfunction

  function automatic logic [7:0] m_code(input int a, input int e);
    int r;
    r = m_reveal(e);
    if (a < r) return rom_fn(a);
    if (m_typing(e) && a == r && m_cursor(e)) return 8'h5F;
    return 8'h20;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int a, input bit st, input bit sk);
    exp_t x;
    int   e;
    @(negedge clk);
    bus.char_xy_in = 8'(a);
    bus.start      = st;
    bus.skip       = sk;
    chk_req        = 1'b1;
    e = edge_cnt + 1;
    if (st) begin
      started    = 1'b1;
      start_edge = e;
      skip_edge  = -1;
    end else if (sk && m_typing(e - 1)) begin
      skip_edge = e;
    end
    x.addr = a;
    x.code = m_code(a, e);
    x.busy = m_typing(e);
    x.done = m_done(e);
    sb_q.push_back(x);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) drive(int'($urandom_range(0, 255)), 1'b0, 1'b0);
  endtask

  task automatic scan(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) drive(a, 1'b0, 1'b0);
  endtask

  // Monitor: compares the DUT against the oldest expectation one step after each checked edge.
  initial begin : monitor
    bit   r;
    exp_t x;
    forever begin
      @(posedge clk);
      r = chk_req;
      #1;
      if (r) begin
        if (sb_q.size() == 0) begin
          check("scoreboard_empty", 0, 1);
        end else begin
          x = sb_q.pop_front();
          check($sformatf("char_code_out@%02h", x.addr), int'(bus.char_code_out), int'(x.code));
          check("busy", int'(bus.busy), int'(x.busy));
          check("done", int'(bus.done), int'(x.done));
          check("char_xy_out", int'(bus.char_xy_out), x.addr);
        end
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.start      = 1'b0;
    bus.skip       = 1'b0;
    bus.char_xy_in = 8'h00;
    chk_req        = 1'b0;
    started        = 1'b0;
    start_edge     = 0;
    skip_edge      = -1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle: everything blank; a stray skip is ignored.
    scan(0, 255);
    drive(5, 1'b0, 1'b1);
    rand_cycles(4);

    // Partial reveal after three ticks.
    drive(int'($urandom_range(0, 255)), 1'b1, 1'b0);
    rand_cycles(11);
    scan(0, 7);
    scan(0, 255);

    // Skip ten cycles into a reveal.
    drive(int'($urandom_range(0, 255)), 1'b1, 1'b0);
    rand_cycles(9);
    drive(int'($urandom_range(0, 255)), 1'b0, 1'b1);
    rand_cycles(4);
    scan(0, 255);

    // Full free-running reveal, then skip in DONE is ignored.
    drive(int'($urandom_range(0, 255)), 1'b1, 1'b0);
    rand_cycles(TL * TD + 12);
    scan(0, 255);
    drive(3, 1'b0, 1'b1);

    // Start and skip together in DONE: restart wins.
    drive(int'($urandom_range(0, 255)), 1'b1, 1'b1);
    rand_cycles(20);
    scan(0, 7);
    rand_cycles(30);

    // Asynchronous reset mid-reveal.
    @(negedge clk);
    chk_req   = 1'b0;
    bus.start = 1'b0;
    bus.skip  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_char_code_out", int'(bus.char_code_out), 8'h20);
    started   = 1'b0;
    skip_edge = -1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rand_cycles(20);
    scan(0, 15);

    @(negedge clk);
    chk_req = 1'b0;
    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/char_reveal_ctrl.md
# char_reveal_ctrl

Typewriter-style reveal controller for the menu text screen. It sits between the character address generator and `char_rom_menu`. It passes the character-cell address through to the ROM. It gates the ROM's registered character code so that only the first `reveal_cnt` cells show text, advancing one cell per tick, with a blinking underscore cursor at the reveal point. `start` begins a reveal, `skip` completes it instantly, and `done` signals completion to the game FSM.

## Interface
- `TEXT_LEN`, 182: number of text cells (0x00..0xB5); must be ≤ 255.
- `TICK_DIV`, 2_600_000: `clk` cycles per revealed character; must be ≥ 1.
- `BLINK_DIV`, 32_500_000: `clk` cycles per cursor phase toggle; must be ≥ 1.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse that (re)starts a reveal from cell 0.
- `skip`  in  1  single-cycle pulse that reveals all text immediately.
- `char_xy_in`  in  8  cell address from the character address generator.
- `char_xy_out`  out  8  cell address to `char_rom_menu`; combinational copy of `char_xy_in`.
- `rom_code`  in  8  `char_code` from `char_rom_menu`; valid 1 cycle after `char_xy_out`.
- `char_code_out`  out  8  masked character code to the font stage.
- `busy`  out  1  high while in TYPING.
- `done`  out  1  one-cycle pulse on entry to DONE.

## Operation
- FSM states:
  - IDLE: the reset state.
  - TYPING: the reveal is in progress.
  - DONE: the full text is shown.
- Transitions:
  - Any state, on `start` → TYPING. This clears `reveal_cnt`, `tick_cnt` and `blink_cnt`, and sets `cursor_on` = 1.
  - TYPING, on `skip` (without `start`) → DONE. This sets `reveal_cnt` = `TEXT_LEN`.
  - TYPING, on a tick when `reveal_cnt` = `TEXT_LEN`−1 → DONE. This sets `reveal_cnt` = `TEXT_LEN`.
  - `skip` in IDLE or DONE is ignored.
  - `start` and `skip` in the same cycle: `start` wins.
- Tick generation:
  - `tick_cnt` counts 0..`TICK_DIV`−1 in TYPING only.
  - A tick occurs at `TICK_DIV`−1. On a tick, `tick_cnt` wraps to 0 and `reveal_cnt` increments.
  - `tick_cnt` holds at 0 outside TYPING.
- Cursor blink:
  - `blink_cnt` counts 0..`BLINK_DIV`−1 in TYPING only.
  - On wrap, `cursor_on` toggles.
- Registered address: `xy_d` ← `char_xy_in` every cycle, aligned with `rom_code`.
- Output mux (combinational from `xy_d`, `rom_code` and state):
  - `xy_d` < `reveal_cnt`: output `rom_code`.
  - State TYPING and `xy_d` = `reveal_cnt` and `cursor_on`: output 8'h5F.
  - Otherwise: output 8'h20.
- Result by state:
  - IDLE: all cells blank.
  - DONE: all `TEXT_LEN` cells show ROM text.
  - Cells ≥ `TEXT_LEN` always show 8'h20, because `rom_code` is already a space there and the compare also excludes them.
- Widths:
  - `reveal_cnt` is 8 bits, unsigned compare.
  - `tick_cnt` is $clog2(`TICK_DIV`) bits, with a minimum of 1.
  - `blink_cnt` is $clog2(`BLINK_DIV`) bits, with a minimum of 1.

## Timing
- Reset values:
  - State IDLE.
  - `reveal_cnt`, `tick_cnt`, `blink_cnt` = 0; `cursor_on` = 1.
  - `xy_d` = 0.
  - `busy` = 0, `done` = 0.
  - `char_code_out` = 8'h20.
- `char_xy_in` → `char_code_out` latency is 1 cycle, matching the ROM register.
- `char_xy_out` has zero latency.
- After a `start` pulse in cycle N:
  - `busy` = 1 from cycle N+1.
  - The first tick is at cycle N+`TICK_DIV`.
- `done` is a registered pulse, high for exactly the one cycle in which state first reads DONE.
- `busy` is registered, i.e. (state == TYPING).
- Reset asserted mid-reveal returns all of the above to reset values asynchronously. No `done` is emitted.
- Total reveal time without skip is `TEXT_LEN` × `TICK_DIV` cycles from `start`.

## Structure
- Shared package `menu_pkg` holds:
  - state enum `reveal_state_t` (IDLE, TYPING, DONE);
  - `CHAR_SPACE` = 8'h20;
  - `CHAR_CURSOR` = 8'h5F;
  - `MENU_TEXT_LEN` = 182.
- One sub-module, `tick_divider` (parameter `DIV`; ports `clk`, `rst_n`, `en`, `clr`, `tick`). It is instantiated twice: once for the character tick, once for the blink toggle.

## Test plan
All scenarios use `TICK_DIV`=4, `BLINK_DIV`=6, `TEXT_LEN`=182, and a behavioural ROM model with 1-cycle latency.
- Reset, then scan addresses 0x00..0xFF → `char_code_out` = 8'h20 for every address; `busy` = 0, `done` = 0.
- `start`, wait 3 ticks (12 cycles), scan → addresses 0x00..0x02 show ROM codes 4C/69/74. Address 0x03 shows 5F when `cursor_on`, else 20. Addresses ≥ 0x04 show 20.
- `start`, then `skip` 10 cycles later → `done` high for exactly 1 cycle, `busy` drops. The scan matches the ROM for 0x00..0xB5 and shows 20 above 0xB5.
- Free-run from `start` → `done` at cycle 182×4 after `start`; `reveal_cnt` stops at 182; no further ticks.
- `start` and `skip` in the same cycle while in DONE → state TYPING, `reveal_cnt` = 0, no `done` pulse.
- Assert `rst_n` low mid-TYPING (after 50 cycles) → outputs return to reset values immediately. After release, the state stays IDLE until the next `start`.
